// File: rtl/com_arbiter.sv
// com_arbiter: two requesters share one com comparator; 1-cycle registered result with tag.
// Build option COM_ARB_FIXED_PRIO_EN: req0 always wins a conflict (no last_grant state).

module com #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_lhs,
    input  logic [XLEN-1:0] i_rhs,
    output logic            o_res
);
    typedef enum logic [2:0] {
        COM_OP_EQ  = 3'b000,
        COM_OP_NE  = 3'b001,
        COM_OP_LT  = 3'b100,
        COM_OP_GE  = 3'b101,
        COM_OP_LTU = 3'b110,
        COM_OP_GEU = 3'b111
    } com_op_e;

    com_op_e w_op;
    assign w_op = com_op_e'(i_op);

    always_comb begin
        o_res = 1'b0;
        case (w_op)
            COM_OP_EQ:  o_res = (i_lhs == i_rhs);
            COM_OP_NE:  o_res = (i_lhs != i_rhs);
            COM_OP_LT:  o_res = ($signed(i_lhs) <  $signed(i_rhs));
            COM_OP_GE:  o_res = ($signed(i_lhs) >= $signed(i_rhs));
            COM_OP_LTU: o_res = (i_lhs <  i_rhs);
            COM_OP_GEU: o_res = (i_lhs >= i_rhs);
            default:    o_res = 1'b0;
        endcase
    end
endmodule

module com_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [XLEN-1:0]  req0_lhs,
    input  logic [XLEN-1:0]  req0_rhs,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [XLEN-1:0]  req1_lhs,
    input  logic [XLEN-1:0]  req1_rhs,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp0_res,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic             rsp1_res,
    output logic [TAG_W-1:0] rsp1_tag
);
    logic             r_rsp0_valid;
    logic             r_rsp0_res;
    logic [TAG_W-1:0] r_rsp0_tag;
    logic             r_rsp1_valid;
    logic             r_rsp1_res;
    logic [TAG_W-1:0] r_rsp1_tag;

    logic             w_elig0;
    logic             w_elig1;
    logic             w_grant0;
    logic             w_grant1;
    logic [2:0]       w_op;
    logic [XLEN-1:0]  w_lhs;
    logic [XLEN-1:0]  w_rhs;
    logic             w_res;

    // A slot being drained this cycle can take a new request on the same edge.
    assign w_elig0 = req0_valid && (!r_rsp0_valid || rsp0_ready);
    assign w_elig1 = req1_valid && (!r_rsp1_valid || rsp1_ready);

`ifdef COM_ARB_FIXED_PRIO_EN
    assign w_grant0 = rst_n && w_elig0;
    assign w_grant1 = rst_n && w_elig1 && !w_elig0;
`else
    logic r_last_grant;   // 1: req1 won most recently

    assign w_grant0 = rst_n && w_elig0 && (!w_elig1 || r_last_grant);
    assign w_grant1 = rst_n && w_elig1 && (!w_elig0 || !r_last_grant);
`endif

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_op  = w_grant1 ? req1_op  : req0_op;
    assign w_lhs = w_grant1 ? req1_lhs : req0_lhs;
    assign w_rhs = w_grant1 ? req1_rhs : req0_rhs;

    com #(.XLEN(XLEN)) u_com (
        .i_op  (w_op),
        .i_lhs (w_lhs),
        .i_rhs (w_rhs),
        .o_res (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_res   <= 1'b0;
            r_rsp0_tag   <= '0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_res   <= 1'b0;
            r_rsp1_tag   <= '0;
`ifndef COM_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            if (w_grant0) begin
                r_rsp0_valid <= 1'b1;
                r_rsp0_res   <= w_res;
                r_rsp0_tag   <= req0_tag;
            end else if (rsp0_ready) begin
                r_rsp0_valid <= 1'b0;
            end
            if (w_grant1) begin
                r_rsp1_valid <= 1'b1;
                r_rsp1_res   <= w_res;
                r_rsp1_tag   <= req1_tag;
            end else if (rsp1_ready) begin
                r_rsp1_valid <= 1'b0;
            end
`ifndef COM_ARB_FIXED_PRIO_EN
            if (w_grant0 || w_grant1)
                r_last_grant <= w_grant1;
`endif
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_res   = r_rsp0_res;
    assign rsp0_tag   = r_rsp0_tag;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_res   = r_rsp1_res;
    assign rsp1_tag   = r_rsp1_tag;
endmodule

// File: tb/tb_com_arbiter.sv
// Self-checking bench for com_arbiter: grant model plus per-requester response scoreboard.
// Honours COM_ARB_FIXED_PRIO_EN the same way as the design.
`timescale 1ns/1ps
module tb_com_arbiter;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;
    localparam logic [2:0] OP_BAD = 3'b010;

    typedef struct packed {
        logic [2:0]       op;
        logic [XLEN-1:0]  lhs;
        logic [XLEN-1:0]  rhs;
        logic [TAG_W-1:0] tag;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [XLEN-1:0] req0_lhs, req0_rhs, req1_lhs, req1_rhs;
    logic [TAG_W-1:0] req0_tag, req1_tag, rsp0_tag, rsp1_tag;
    logic rsp0_valid, rsp0_ready, rsp0_res;
    logic rsp1_valid, rsp1_ready, rsp1_res;

    int total = 0;
    int bad   = 0;

    stim_t s0[$];
    stim_t s1[$];
    logic [TAG_W:0] q0[$];
    logic [TAG_W:0] q1[$];

    logic m_v0 = 1'b0, m_v1 = 1'b0, m_last = 1'b1;
    logic acc0 = 1'b0, acc1 = 1'b0;
    logic hold0 = 1'b0, hold1 = 1'b0;
    logic [TAG_W:0] held0, held1;

    always #5 clk = ~clk;

    com_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_lhs(req0_lhs), .req0_rhs(req0_rhs), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_lhs(req1_lhs), .req1_rhs(req1_rhs), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_tag(rsp1_tag)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", nm, $time, got, exp);
        end
    endtask

    function automatic logic ref_cmp(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_EQ:   return a == b;
            OP_NE:   return a != b;
            OP_LT:   return sa < sb;
            OP_GE:   return sa >= sb;
            OP_LTU:  return a < b;
            OP_GEU:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: inputs change only at posedge+1 (or +3 for reset), so negedge sees edge values.
    always @(negedge clk) begin
        logic e0, e1, g0, g1;
        if (!rst_n) begin
            check("rst_rdy0", req0_ready, 1'b0);
            check("rst_rdy1", req1_ready, 1'b0);
            check("rst_v0", rsp0_valid, 1'b0);
            check("rst_v1", rsp1_valid, 1'b0);
            q0.delete(); q1.delete();
            m_v0 = 1'b0; m_v1 = 1'b0; m_last = 1'b1;
            acc0 = 1'b0; acc1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
        end else begin
            e0 = req0_valid && (!m_v0 || rsp0_ready);
            e1 = req1_valid && (!m_v1 || rsp1_ready);
`ifdef COM_ARB_FIXED_PRIO_EN
            g0 = e0;
            g1 = e1 && !e0;
`else
            if (e0 && e1) begin
                g0 = m_last;
                g1 = !m_last;
            end else begin
                g0 = e0;
                g1 = e1;
            end
`endif
            check("rdy0", req0_ready, g0);
            check("rdy1", req1_ready, g1);
            check("v0", rsp0_valid, m_v0);
            check("v1", rsp1_valid, m_v1);
            if (hold0) check("hold0", {rsp0_res, rsp0_tag}, held0);
            if (hold1) check("hold1", {rsp1_res, rsp1_tag}, held1);
            if (m_v0 && rsp0_ready && q0.size() > 0) check("rsp0", {rsp0_res, rsp0_tag}, q0.pop_front());
            if (m_v1 && rsp1_ready && q1.size() > 0) check("rsp1", {rsp1_res, rsp1_tag}, q1.pop_front());
            hold0 = m_v0 && !rsp0_ready && !g0;
            hold1 = m_v1 && !rsp1_ready && !g1;
            held0 = {rsp0_res, rsp0_tag};
            held1 = {rsp1_res, rsp1_tag};
            if (g0) q0.push_back({ref_cmp(req0_op, req0_lhs, req0_rhs), req0_tag});
            if (g1) q1.push_back({ref_cmp(req1_op, req1_lhs, req1_rhs), req1_tag});
            m_v0 = g0 ? 1'b1 : (rsp0_ready ? 1'b0 : m_v0);
            m_v1 = g1 ? 1'b1 : (rsp1_ready ? 1'b0 : m_v1);
            if (g0 || g1) m_last = g1;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
        end
    end

    task automatic drive_update();
        stim_t st;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        if (!req0_valid && s0.size() > 0) begin
            st = s0.pop_front();
            {req0_op, req0_lhs, req0_rhs, req0_tag} = st;
            req0_valid = 1'b1;
        end
        if (!req1_valid && s1.size() > 0) begin
            st = s1.pop_front();
            {req1_op, req1_lhs, req1_rhs, req1_tag} = st;
            req1_valid = 1'b1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_update();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        while (!(s0.size() == 0 && s1.size() == 0 && !req0_valid && !req1_valid
                 && !m_v0 && !m_v1) && n < 60) begin
            run(1);
            n++;
        end
        check("drain_timeout", (n < 60), 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req0_lhs = '0; req0_rhs = '0; req0_tag = '0;
        req1_op = '0; req1_lhs = '0; req1_rhs = '0; req1_tag = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #12;
        check("rst_res0", rsp0_res, 1'b0);
        check("rst_tag0", rsp0_tag, 4'd0);
        check("rst_res1", rsp1_res, 1'b0);
        check("rst_tag1", rsp1_tag, 4'd0);
        run(2);
        #2 rst_n = 1'b1;
        run(1);

        // Single compare
        rsp0_ready = 1'b1;
        s0.push_back('{OP_EQ, 32'h5, 32'h5, 4'd3});
        drain();

        // Signed vs unsigned on requester 1
        s1.push_back('{OP_LT,  32'hFFFF_FFFF, 32'h1, 4'd1});
        s1.push_back('{OP_LTU, 32'hFFFF_FFFF, 32'h1, 4'd2});
        s1.push_back('{OP_GE,  32'hFFFF_FFFF, 32'h1, 4'd3});
        s1.push_back('{OP_GEU, 32'hFFFF_FFFF, 32'h1, 4'd4});
        s1.push_back('{OP_NE,  32'h7, 32'h7, 4'd5});
        drain();

        // Contention with random operands
        for (int i = 0; i < 8; i++) begin
            s0.push_back('{3'($urandom_range(0, 7)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), 4'(i)});
            s1.push_back('{3'($urandom_range(0, 7)), 32'($urandom), 32'($urandom), 4'(15 - i)});
        end
        drain();

        // Backpressure on rsp0
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        s0.push_back('{OP_EQ, 32'h9, 32'h9, 4'd5});
        run(2);
        s0.push_back('{OP_NE, 32'h9, 32'h9, 4'd6});
        for (int i = 0; i < 6; i++)
            s1.push_back('{OP_LTU, 32'(i), 32'd3, 4'(i + 8)});
        run(6);
        rsp0_ready = 1'b1;
        run(1);
        drain();

        // Undefined op, operands equal
        s0.push_back('{OP_BAD, 32'h0, 32'h0, 4'd7});
        s1.push_back('{3'b011, 32'h0, 32'h0, 4'd2});
        drain();

        // Async reset with a pending rsp1
        rsp1_ready = 1'b0;
        s1.push_back('{OP_EQ, 32'h1, 32'h1, 4'd9});
        run(3);
        check("pre_rst_v1", rsp1_valid, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_v1", rsp1_valid, 1'b0);
        check("mid_rst_tag1", rsp1_tag, 4'd0);
        rsp1_ready = 1'b1;
        rsp0_ready = 1'b1;
        s0.push_back('{OP_GEU, 32'h3, 32'h2, 4'd10});
        s1.push_back('{OP_LT, 32'h3, 32'h2, 4'd11});
        run(2);
        check("rst_hold_rdy0", req0_ready, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("post_rst_first0", req0_ready, 1'b1);
        check("post_rst_first1", req1_ready, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/com_arbiter.md
Name: com_arbiter

Overview:
- Shares one `com` comparator instance between two requesters: req0 (branch resolve path) and req1 (SLT/SLTU execute path).
- Arbitrates round-robin, issues at most one compare per cycle, and returns a registered 1-bit result with a tag on a per-requester response channel.
- Valid/ready handshakes on all channels; sits between decode/issue and the writeback/branch-redirect logic.

Parameters:
- XLEN, 32, operand width; the internal `com` operands are XLEN bits (REG_END_WORD = XLEN-1).
- TAG_W, 4, width of the opaque tag carried from request to response.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a compare
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  3  compare op, COM_OP_* encoding from defs.vh
- req0_lhs  in  XLEN  left operand
- req0_rhs  in  XLEN  right operand
- req0_tag  in  TAG_W  opaque tag
- req1_valid, req1_ready, req1_op, req1_lhs, req1_rhs, req1_tag: same as req0 for requester 1
- rsp0_valid  out  1  result pending for requester 0
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_res  out  1  compare result
- rsp0_tag  out  TAG_W  tag of the accepted request
- rsp1_valid, rsp1_ready, rsp1_res, rsp1_tag: same as rsp0 for requester 1

Behaviour:
- Reset (async assert, sync release): rsp0_valid = rsp1_valid = 0; rsp*_res = 0; rsp*_tag = 0; last_grant = 1, so req0 wins the first conflict.
- Eligibility: eligK = reqK_valid && (!rspK_valid || rspK_ready). A slot that is being drained this cycle may accept a new request.
- Grant:
  - Only one eligible: it wins.
  - Both eligible: the requester not equal to last_grant wins.
  - reqK_ready = grantK, combinational; it may depend on reqK_valid and rspK_ready.
  - At most one reqK_ready is high per cycle.
- Compare: the granted op, lhs and rhs mux into the single `com` instance in the same cycle. Undefined op codes yield res = 0 and are still accepted and answered.
- Latency is 1: a request accepted at edge N gives rspK_valid = 1 with res and tag from edge N onward (visible in cycle N+1).
- Hold: rspK_valid, rspK_res and rspK_tag stay stable until the edge where rspK_ready = 1.
  - On that edge, if no new grant for K: rspK_valid goes to 0.
  - If a new grant for K on the same edge: rspK_valid stays 1 with the new res/tag (back-to-back throughput of 1 per cycle per requester).
- last_grant updates only on an edge where a grant occurs; idle cycles leave it unchanged.
- Full response slot with rspK_ready = 0: reqK is not granted. The other requester may be granted in the same cycle; no head-of-line blocking.
- rspK_ready while rspK_valid = 0 is ignored.
- Reset mid-operation clears pending responses and they are lost; no request is granted while rst_n = 0.
- Requesters must hold op/lhs/rhs/tag stable while valid && !ready. The block does not check this.

Optional Feature:
- Macro: COM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; req0 always wins when both are eligible. last_grant is not implemented; reset state otherwise identical.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- Single compare: reset, then req0 EQ, lhs = 0x5, rhs = 0x5, tag = 3, rsp0_ready = 1 -> req0_ready = 1 in the same cycle; next cycle rsp0_valid = 1, res = 1, tag = 3; following cycle rsp0_valid = 0.
- Signed vs unsigned: req1 LT with lhs = 0xFFFFFFFF, rhs = 0x1 -> res = 1; repeat with LTU -> res = 0; GE and GEU with the same operands -> 0 and 1.
- Contention: both valid every cycle, both rsp_ready = 1 -> grants alternate req0, req1, req0, ..., starting with req0 after reset; each rsp_valid pulses every other cycle. With COM_ARB_FIXED_PRIO_EN -> req0 granted every cycle and req1 never.
- Backpressure: rsp0_ready = 0 with a pending result, req0 and req1 both valid -> req0_ready = 0, req1 granted; rsp0 res/tag stay stable for 5 cycles; then rsp0_ready = 1 -> req0 granted on the same edge and rsp0_valid stays 1 with the new tag.
- Undefined op: req0 op not in COM_OP_*, lhs = rhs = 0 -> accepted, rsp0_res = 0.
- Async reset mid-flight: assert rst_n = 0 between edges with rsp1_valid = 1 -> rsp1_valid = 0 immediately (before the next edge), no ready during reset; after release the first conflict goes to req0.
